// File: rtl/wbsram_pkg.sv
// -----------------------------------------------------------------------------
// wbsram_pkg
//   Shared types and elaboration-time helpers for the Wishbone-to-async-SRAM
//   controller (wbsram_ctrl) and its beat timer.
//
//   Contents:
//     state_t         controller phase: idle, CE-low beat, CE-high recovery, ack
//     nb_of()         RAM beats per bus word
//     lgnb_of()       width of the beat index / RAM address extension
//     params_legal()  parameter combination sanity check
//     next_live_beat() first beat at or after 'from' that is not skipped
// -----------------------------------------------------------------------------
package wbsram_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    // Upper bound on beats per word; sizes the skip mask seen by helpers.
    localparam int MAX_BEATS = 64;

    function automatic int nb_of(input int dw, input int ramdw);
        return dw / ramdw;
    endfunction

    function automatic int lgnb_of(input int dw, input int ramdw);
        return $clog2(nb_of(dw, ramdw));
    endfunction

    function automatic bit params_legal(input int dw, input int ramdw,
                                        input int wait_cyc, input int gap_cyc);
        return (ramdw >= 8) && (ramdw % 8 == 0) && (dw % ramdw == 0)
            && (nb_of(dw, ramdw) >= 2) && (nb_of(dw, ramdw) <= MAX_BEATS)
            && (wait_cyc >= 2) && (gap_cyc >= 1);
    endfunction

    // Returns nb when every remaining beat is skipped (or from >= nb).
    function automatic int next_live_beat(input logic [MAX_BEATS-1:0] skip,
                                          input int from, input int nb);
        int res;
        res = nb;
        for (int k = MAX_BEATS - 1; k >= 0; k--) begin
            if (k >= from && k < nb && !skip[k]) res = k;
        end
        return res;
    endfunction

endpackage

// File: rtl/wbsram_if.sv
// -----------------------------------------------------------------------------
// wbsram_if
//   Pipelined Wishbone (classic-stall) bundle between the interconnect and
//   the SRAM controller.
//
//   Signals: cyc, stb, we, addr[AW], wdata[DW], sel[DW/8] (master -> slave)
//            stall, ack, rdata[DW]                      (slave -> master)
//   Modports: master (bus initiator), slave (wbsram_ctrl)
// -----------------------------------------------------------------------------
interface wbsram_if #(
    parameter int AW = 15,
    parameter int DW = 32
) ();

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] sel;
    logic          stall;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, rdata
    );

endinterface

// File: rtl/wbsram_beat_timer.sv
// -----------------------------------------------------------------------------
// wbsram_beat_timer
//   Phase down-counter (WAIT cycles of CE low, GAP cycles of recovery) and
//   beat index for wbsram_ctrl. Skipped beats are jumped over when advancing.
//
//   Ports:
//     i_clk, i_reset_n  clock, synchronous active-low reset
//     state             controller phase driving the counter
//     start             request accepted; load first beat and WAIT count
//     start_beat        first beat of the new request
//     skip[NB]          beats that are not strobed
//     first_active      first cycle of a CE-low phase
//     last_active       last cycle of a CE-low phase
//     gap_done          last cycle of a recovery phase
//     last_beat         no un-skipped beat follows the current one
//     beat_idx          current beat
//     next_beat         beat that follows the current one
// -----------------------------------------------------------------------------
module wbsram_beat_timer
    import wbsram_pkg::*;
#(
    parameter int NB   = 2,
    parameter int LGNB = 1,
    parameter int WAIT = 2,
    parameter int GAP  = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  state_t          state,
    input  logic            start,
    input  logic [LGNB-1:0] start_beat,
    input  logic [NB-1:0]   skip,
    output logic            first_active,
    output logic            last_active,
    output logic            gap_done,
    output logic            last_beat,
    output logic [LGNB-1:0] beat_idx,
    output logic [LGNB-1:0] next_beat
);

    localparam int CW = $clog2(((WAIT > GAP) ? WAIT : GAP) + 1);

    logic [CW-1:0]   cnt;
    logic [LGNB-1:0] beat;
    int              nxt;

    // NOTE: every output is assigned on every pass through this block, so no
    // path leaves a value held and no latch can be inferred.
    always_comb begin
        nxt          = next_live_beat(MAX_BEATS'(skip), int'(beat) + 1, NB);
        last_beat    = (nxt >= NB);
        next_beat    = LGNB'(nxt);
        beat_idx     = beat;
        first_active = (state == S_ACTIVE) && (cnt == CW'(WAIT - 1));
        last_active  = (state == S_ACTIVE) && (cnt == '0);
        gap_done     = (state == S_GAP) && (cnt == '0);
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt  <= '0;
            beat <= '0;
        end else if (start) begin
            cnt  <= CW'(WAIT - 1);
            beat <= start_beat;
        end else begin
            case (state)
                S_ACTIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!last_beat) begin
                        // Beat advances on entry to recovery so address and
                        // data settle while CE is high.
                        cnt  <= CW'(GAP - 1);
                        beat <= next_beat;
                    end
                end
                S_GAP: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    else           cnt <= CW'(WAIT - 1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wbsram_ctrl.sv
// -----------------------------------------------------------------------------
// wbsram_ctrl
//   Pipelined Wishbone slave driving an asynchronous SRAM narrower than the
//   bus. Each DW-bit request becomes NB = DW/RAMDW RAM beats, MSB beat first.
//   Each beat holds CE low for WAIT cycles, beats are separated by GAP cycles
//   of CE high, and the ack cycle (DONE) can accept the next request.
//
//   Build option: define WBSRAM_BYTESKIP_EN to drop write beats whose byte
//   enables are all zero (no strobe, no recovery time for that beat).
//
//   Ports:
//     i_clk, i_reset_n  clock, synchronous active-low reset
//     wb                Wishbone slave (cyc/stb/we/addr/wdata/sel in,
//                       stall/ack/rdata out)
//     o_ram_ce_n        chip enable, active low
//     o_ram_oe_n        output enable, active low
//     o_ram_we_n        write enable, active low
//     o_ram_addr        {wb address, beat index}
//     o_ram_data        write data for the current beat
//     o_ram_sel         byte lanes, active low
//     i_ram_data        read data from the SRAM
// -----------------------------------------------------------------------------
module wbsram_ctrl
    import wbsram_pkg::*;
#(
    parameter  int AW    = 15,
    parameter  int DW    = 32,
    parameter  int RAMDW = 16,
    parameter  int WAIT  = 2,
    parameter  int GAP   = 1,
    localparam int NB    = nb_of(DW, RAMDW),
    localparam int LGNB  = lgnb_of(DW, RAMDW),
    localparam int SW    = RAMDW / 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    wbsram_if.slave              wb,
    output logic                 o_ram_ce_n,
    output logic                 o_ram_oe_n,
    output logic                 o_ram_we_n,
    output logic [AW+LGNB-1:0]   o_ram_addr,
    output logic [RAMDW-1:0]     o_ram_data,
    output logic [SW-1:0]        o_ram_sel,
    input  logic [RAMDW-1:0]     i_ram_data
);

    if (!params_legal(DW, RAMDW, WAIT, GAP)) begin : g_bad_params
        $error("wbsram_ctrl: illegal DW/RAMDW/WAIT/GAP combination");
    end

    state_t          state;
    logic            we_r;
    logic            pending;
    logic            stall_r;
    logic            ack_r;
    logic [DW-1:0]   data_r;
    logic [DW-1:0]   rdata_r;
    logic [DW/8-1:0] sel_r;       // stored RAM lanes, active low
    logic [NB-1:0]   skip_r;
    logic [NB-1:0]   skip_new;
    int              start_beat;
    logic [LGNB-1:0] start_idx;
    logic            accept;
    logic            first_active;
    logic            last_active;
    logic            gap_done;
    logic            last_beat;
    logic [LGNB-1:0] beat_idx;
    logic [LGNB-1:0] next_beat;

    function automatic logic [RAMDW-1:0] data_slice(input logic [DW-1:0] d,
                                                    input logic [LGNB-1:0] k);
        return d[DW-1-int'(k)*RAMDW -: RAMDW];
    endfunction

    function automatic logic [SW-1:0] sel_slice(input logic [DW/8-1:0] s,
                                                input logic [LGNB-1:0] k);
        return s[DW/8-1-int'(k)*SW -: SW];
    endfunction

    // stall is low only in IDLE and DONE, so this accepts in exactly those.
    assign accept = wb.stb && !stall_r && (state == S_IDLE || state == S_DONE);

    always_comb begin
        skip_new = '0;
`ifdef WBSRAM_BYTESKIP_EN
        for (int k = 0; k < NB; k++) begin
            skip_new[k] = wb.we && (wb.sel[DW/8-1-k*SW -: SW] == '0);
        end
`endif
        start_beat = next_live_beat(MAX_BEATS'(skip_new), 0, NB);
        start_idx  = LGNB'(start_beat);
    end

    wbsram_beat_timer #(
        .NB   (NB),
        .LGNB (LGNB),
        .WAIT (WAIT),
        .GAP  (GAP)
    ) u_timer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .state        (state),
        .start        (accept && (start_beat < NB)),
        .start_beat   (start_idx),
        .skip         (skip_r),
        .first_active (first_active),
        .last_active  (last_active),
        .gap_done     (gap_done),
        .last_beat    (last_beat),
        .beat_idx     (beat_idx),
        .next_beat    (next_beat)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            o_ram_ce_n <= 1'b1;
            o_ram_oe_n <= 1'b1;
            o_ram_we_n <= 1'b1;
            o_ram_sel  <= '1;
            o_ram_addr <= '0;
            o_ram_data <= '0;
            ack_r      <= 1'b0;
            stall_r    <= 1'b0;
            rdata_r    <= '0;
            pending    <= 1'b0;
            we_r       <= 1'b0;
            data_r     <= '0;
            sel_r      <= '0;
            skip_r     <= '0;
        end else begin
            ack_r <= 1'b0;
            // A master that drops cyc abandons its ack; the RAM cycle still
            // runs to completion so no write is cut off mid-strobe.
            if (!wb.cyc) pending <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (accept) begin
                        we_r    <= wb.we;
                        data_r  <= wb.wdata;
                        sel_r   <= wb.we ? ~wb.sel : '0;
                        skip_r  <= skip_new;
                        pending <= wb.cyc;
                        if (start_beat >= NB) begin
                            // Every beat skipped: acknowledge immediately.
                            state <= S_DONE;
                            ack_r <= wb.cyc;
                        end else begin
                            state      <= S_ACTIVE;
                            stall_r    <= 1'b1;
                            o_ram_ce_n <= 1'b0;
                            o_ram_oe_n <= wb.we;
                            o_ram_we_n <= !wb.we;
                            // Writes open with all lanes off for setup.
                            o_ram_sel  <= wb.we ? '1 : '0;
                            o_ram_addr <= {wb.addr, start_idx};
                            o_ram_data <= data_slice(wb.wdata, start_idx);
                        end
                    end
                end

                S_ACTIVE: begin
                    if (last_active) begin
                        rdata_r[DW-1-int'(beat_idx)*RAMDW -: RAMDW] <= i_ram_data;
                        o_ram_ce_n <= 1'b1;
                        o_ram_oe_n <= 1'b1;
                        o_ram_we_n <= 1'b1;
                        o_ram_sel  <= '1;
                        if (last_beat) begin
                            state   <= S_DONE;
                            stall_r <= 1'b0;
                            ack_r   <= pending && wb.cyc;
                        end else begin
                            state                  <= S_GAP;
                            o_ram_addr[LGNB-1:0]   <= next_beat;
                            o_ram_data             <= data_slice(data_r, next_beat);
                        end
                    end else if (first_active && we_r) begin
                        o_ram_sel <= sel_slice(sel_r, beat_idx);
                    end
                end

                S_GAP: begin
                    if (gap_done) begin
                        state      <= S_ACTIVE;
                        o_ram_ce_n <= 1'b0;
                        o_ram_oe_n <= we_r;
                        o_ram_we_n <= !we_r;
                        o_ram_sel  <= we_r ? '1 : '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign wb.stall = stall_r;
    assign wb.ack   = ack_r;
    assign wb.rdata = rdata_r;

endmodule

// File: tb/tb_wbsram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wbsram_ctrl
//   Directed bench for wbsram_ctrl. dut_a uses the default parameters
//   (32/16, WAIT=2, GAP=1); dut_b uses 32/8 with WAIT=3, GAP=1. Each run
//   records pins per cycle, cycle 1 being the first cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_wbsram_ctrl;

    logic i_clk;
    logic i_reset_n;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    wbsram_if #(.AW(15), .DW(32)) bus_a ();
    wbsram_if #(.AW(15), .DW(32)) bus_b ();

    logic        ce_a, oe_a, we_a;
    logic [15:0] addr_a;
    logic [15:0] wdat_a;
    logic [1:0]  sel_a;
    logic [15:0] din_a;

    logic        ce_b, oe_b, we_b;
    logic [16:0] addr_b;
    logic [7:0]  wdat_b;
    logic [0:0]  sel_b;
    logic [7:0]  din_b;

    wbsram_ctrl dut_a (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .wb         (bus_a),
        .o_ram_ce_n (ce_a),
        .o_ram_oe_n (oe_a),
        .o_ram_we_n (we_a),
        .o_ram_addr (addr_a),
        .o_ram_data (wdat_a),
        .o_ram_sel  (sel_a),
        .i_ram_data (din_a)
    );

    wbsram_ctrl #(.AW(15), .DW(32), .RAMDW(8), .WAIT(3), .GAP(1)) dut_b (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .wb         (bus_b),
        .o_ram_ce_n (ce_b),
        .o_ram_oe_n (oe_b),
        .o_ram_we_n (we_b),
        .o_ram_addr (addr_b),
        .o_ram_data (wdat_b),
        .o_ram_sel  (sel_b),
        .i_ram_data (din_b)
    );

    // SRAM models: drive data only while CE and OE are both low.
    function automatic logic [15:0] mem_a(input logic [15:0] a);
        case (a)
            16'h0246: return 16'hBEEF;
            16'h0247: return 16'hCAFE;
            default:  return 16'h0BAD;
        endcase
    endfunction

    assign din_a = (!ce_a && !oe_a) ? mem_a(addr_a) : 16'h0000;
    assign din_b = (!ce_b && !oe_b) ? (addr_b[7:0] + 8'h11) : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle traces; vectors shift in so cycle 1 lands in the MSB.
    logic [31:0] vce_a, voe_a, vack_a, vstall_a, vce_b, vack_b;
    logic [15:0] tr_addr_a [0:31];
    logic [15:0] tr_data_a [0:31];
    logic [1:0]  tr_sel_a  [0:31];
    logic [31:0] tr_rd_a   [0:31];
    logic [16:0] tr_addr_b [0:31];
    logic [7:0]  tr_data_b [0:31];
    logic [0:0]  tr_sel_b  [0:31];
    logic [31:0] tr_rd_b   [0:31];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic req_a(input logic we, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = we;
        bus_a.addr = a; bus_a.wdata = d; bus_a.sel = s;
    endtask

    task automatic req_b(input logic we, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bus_b.cyc = 1'b1; bus_b.stb = 1'b1; bus_b.we = we;
        bus_b.addr = a; bus_b.wdata = d; bus_b.sel = s;
    endtask

    // Runs n cycles after the acceptance edge. stb_off/cyc_off/rst_at name
    // the cycle in which stb drops, cyc drops, or reset is asserted.
    task automatic run(input int n, input int stb_off, input int cyc_off,
                       input int rst_at);
        vce_a = '0; voe_a = '0; vack_a = '0; vstall_a = '0;
        vce_b = '0; vack_b = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge i_clk);
            #1;
            if (c == stb_off) begin bus_a.stb = 1'b0; bus_b.stb = 1'b0; end
            if (c == cyc_off) begin bus_a.cyc = 1'b0; bus_b.cyc = 1'b0; end
            if (c == rst_at)     i_reset_n = 1'b0;
            if (c == rst_at + 1) i_reset_n = 1'b1;
            vce_a    = {vce_a[30:0], ce_a};
            voe_a    = {voe_a[30:0], oe_a};
            vack_a   = {vack_a[30:0], bus_a.ack};
            vstall_a = {vstall_a[30:0], bus_a.stall};
            vce_b    = {vce_b[30:0], ce_b};
            vack_b   = {vack_b[30:0], bus_b.ack};
            tr_addr_a[c] = addr_a; tr_data_a[c] = wdat_a;
            tr_sel_a[c]  = sel_a;  tr_rd_a[c]   = bus_a.rdata;
            tr_addr_b[c] = addr_b; tr_data_b[c] = wdat_b;
            tr_sel_b[c]  = sel_b;  tr_rd_b[c]   = bus_b.rdata;
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        bus_a.cyc = 0; bus_a.stb = 0; bus_a.we = 0;
        bus_a.addr = '0; bus_a.wdata = '0; bus_a.sel = '0;
        bus_b.cyc = 0; bus_b.stb = 0; bus_b.we = 0;
        bus_b.addr = '0; bus_b.wdata = '0; bus_b.sel = '0;
        idle(3);

        // Reset state
        check("rst_strobes", {ce_a, oe_a, we_a}, 3'b111);
        check("rst_sel", sel_a, 2'b11);
        check("rst_ack_stall", {bus_a.ack, bus_a.stall}, 2'b00);
        check("rst_rdata", bus_a.rdata, 32'h0);
        check("rst_addr_data", {addr_a, wdat_a}, 32'h0);
        i_reset_n = 1'b1;
        idle(2);

        // 1: read 0x0123 -> beats at 0x246/0x247
        req_a(1'b0, 15'h0123, 32'h0, 4'hF);
        run(6, 1, 0, 0);
        check("t1_ce", vce_a[5:0], 6'b001001);
        check("t1_oe", voe_a[5:0], 6'b001001);
        check("t1_ack", vack_a[5:0], 6'b000001);
        check("t1_stall", vstall_a[5:0], 6'b111110);
        check("t1_addr", {tr_addr_a[1], tr_addr_a[4]}, 32'h0246_0247);
        check("t1_sel", {tr_sel_a[1], tr_sel_a[2], tr_sel_a[4]}, 6'b000000);
        check("t1_rdata", tr_rd_a[6], 32'hBEEFCAFE);
        idle(2);

        // 2: write 0xDEADBEEF, sel 1100, addr 5
        req_a(1'b1, 15'h0005, 32'hDEADBEEF, 4'b1100);
        run(6, 1, 0, 0);
        check("t2_addr0", tr_addr_a[1], 16'h000A);
        check("t2_data0", tr_data_a[1], 16'hDEAD);
        check("t2_sel0", {tr_sel_a[1], tr_sel_a[2]}, 4'b1100);
`ifdef WBSRAM_BYTESKIP_EN
        check("t2_ce_skip", vce_a[5:0], 6'b001111);
        check("t2_ack_skip", vack_a[5:0], 6'b001000);
`else
        check("t2_ce", vce_a[5:0], 6'b001001);
        check("t2_addr1", tr_addr_a[4], 16'h000B);
        check("t2_data1", tr_data_a[4], 16'hBEEF);
        check("t2_sel1", {tr_sel_a[3], tr_sel_a[4], tr_sel_a[5]}, 6'b111111);
        check("t2_ack", vack_a[5:0], 6'b000001);
`endif
        idle(2);

        // 3: stb held through stall -> back-to-back requests
        req_a(1'b0, 15'h0123, 32'h0, 4'hF);
        run(12, 7, 0, 0);
        check("t3_ack", vack_a[11:0], 12'b000001_000001);
        check("t3_ce", vce_a[11:0], 12'b001001_001001);
        check("t3_stall", vstall_a[11:0], 12'b111110_111110);
        check("t3_rdata", tr_rd_a[12], 32'hBEEFCAFE);
        idle(2);

        // 4: cyc dropped in cycle 3 -> strobes finish, no ack
        req_a(1'b0, 15'h0123, 32'h0, 4'hF);
        run(8, 1, 3, 0);
        check("t4_ack", vack_a[7:0], 8'h00);
        check("t4_ce", vce_a[7:0], 8'b00100111);
        check("t4_stall", vstall_a[7:0], 8'b11111000);
        idle(2);

        // 5: reset in cycle 3 aborts; a later request completes
        req_a(1'b0, 15'h0123, 32'h0, 4'hF);
        run(8, 1, 0, 3);
        check("t5_ce", vce_a[7:0], 8'b00111111);
        check("t5_stall", vstall_a[7:0], 8'b11100000);
        check("t5_ack", vack_a[7:0], 8'h00);
        idle(2);
        req_a(1'b0, 15'h0123, 32'h0, 4'hF);
        run(6, 1, 0, 0);
        check("t5_after_ack", vack_a[5:0], 6'b000001);
        check("t5_after_rdata", tr_rd_a[6], 32'hBEEFCAFE);
        idle(2);

        // 6: 32/8, WAIT=3 read -> 4 beats, ack in cycle 16
        req_b(1'b0, 15'h0010, 32'h0, 4'hF);
        run(16, 1, 0, 0);
        check("t6_addr_lsb", {tr_addr_b[1][1:0], tr_addr_b[5][1:0],
                              tr_addr_b[9][1:0], tr_addr_b[13][1:0]}, 8'b00_01_10_11);
        check("t6_addr_hi", tr_addr_b[1], 17'h00040);
        check("t6_ce", vce_b[15:0], 16'h1111);
        check("t6_ack", vack_b[15:0], 16'h0001);
        check("t6_rdata", tr_rd_b[16], 32'h51525354);
        idle(2);

        // 6b: 32/8 write with sel 0001
        req_b(1'b1, 15'h0020, 32'h11223344, 4'b0001);
        run(16, 1, 0, 0);
`ifdef WBSRAM_BYTESKIP_EN
        check("t6w_addr_skip", tr_addr_b[1], 17'h00083);
        check("t6w_data_skip", tr_data_b[1], 8'h44);
        check("t6w_sel_skip", {tr_sel_b[1], tr_sel_b[2]}, 2'b10);
        check("t6w_ce_skip", vce_b[15:0], 16'h1FFF);
        check("t6w_ack_skip", vack_b[15:0], 16'h1000);
`else
        check("t6w_sel", {tr_sel_b[2], tr_sel_b[13], tr_sel_b[14]}, 3'b110);
        check("t6w_data3", tr_data_b[13], 8'h44);
        check("t6w_ce", vce_b[15:0], 16'h1111);
        check("t6w_ack", vack_b[15:0], 16'h0001);
`endif
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wbsram_ctrl.md
Name: wbsram_ctrl

Overview:
Parametrised Wishbone (pipelined, classic-stall) slave that drives an external asynchronous SRAM narrower than the bus.
- Splits each DW-bit request into NB = DW/RAMDW sequential RAM beats, MSB beat first.
- RAM strobe width and inter-beat recovery time are configurable.
- A new request is accepted in the same cycle as the previous ack.
- Sits between the ZipCPU bus interconnect and the board SRAM pins; replaces the fixed 32/16, 8-state controller.

Parameters:
AW, 15, Wishbone word-address width
DW, 32, Wishbone data width; must be a multiple of RAMDW
RAMDW, 16, SRAM data width; multiple of 8
WAIT, 2, cycles CE held low per beat; minimum 2
GAP, 1, cycles CE held high between beats; minimum 1

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  synchronous active-low reset
i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone control
i_wb_addr  in  AW  word address
i_wb_data  in  DW  write data
i_wb_sel  in  DW/8  byte enables, active high
o_wb_stall, o_wb_ack  out  1 each  Wishbone handshake
o_wb_data  out  DW  read data
o_ram_ce_n, o_ram_oe_n, o_ram_we_n  out  1 each  SRAM strobes, active low
o_ram_addr  out  AW+log2(NB)  RAM address = {wb_addr, beat index}
o_ram_data  out  RAMDW  RAM write data
o_ram_sel  out  RAMDW/8  RAM byte lanes, active low
i_ram_data  in  RAMDW  RAM read data

Behaviour:
- Reset, synchronous on i_reset_n==0:
  - state IDLE; o_ram_ce_n/oe_n/we_n = 1; o_ram_sel all ones.
  - o_wb_ack = 0, o_wb_stall = 0; o_wb_data, o_ram_addr, o_ram_data = 0.
  - Reset mid-transaction aborts on the next edge: no ack, and the RAM strobes are high in the following cycle.
- States:
  - IDLE: accepts when i_wb_stb && !o_wb_stall (cycle 0). Latches addr, data, we, and sel. Stored RAM sel is ~i_wb_sel for writes and all zeros for reads. Goes to ACTIVE, beat 0.
  - ACTIVE: lasts WAIT cycles. CE low, oe_n = we, we_n = !we.
    - Writes: the first cycle has sel all ones (address/data setup); the remaining cycles drive the beat's sel slice.
    - Reads: sel all zeros throughout.
    - The last ACTIVE cycle registers i_ram_data into the beat's o_wb_data slice.
  - GAP: lasts GAP cycles with CE/OE/WE high and sel all ones. Advances the beat index, o_ram_addr LSBs, and o_ram_data to the next slice; then returns to ACTIVE.
  - After the last beat's ACTIVE phase the block enters DONE (one cycle) instead of GAP.
    - o_wb_ack = (ack pending) && i_wb_cyc.
    - stall = 0, CE high; then IDLE.
    - A stb present in DONE is accepted (behaves as IDLE acceptance).
- Latency: ack in cycle NB*WAIT + (NB-1)*GAP + 1. Defaults give cycle 6.
- o_wb_stall is high from cycle 1 through the cycle before DONE. At most one request is outstanding.
- i_wb_cyc low during a transaction clears the ack-pending flag. The RAM sequence still completes (no partial writes abandoned mid-strobe), and no ack is issued.
- Beat k uses data bits [DW-1-k*RAMDW -: RAMDW]; the same ordering applies to sel.
- CE is high for at least one cycle between any two beats or transactions.

Optional Feature:
WBSRAM_BYTESKIP_EN:
- Defined: a write beat whose sel slice is all zero is skipped entirely (no CE pulse, no GAP, no beat cycles). A write with i_wb_sel==0 acks in cycle 1.
- Undefined: every beat is strobed, with sel all ones for unselected lanes.
- Reads are unaffected in both cases.

Decomposition:
- Package wbsram_pkg: state enum (IDLE, ACTIVE, GAP, DONE), function for NB, function for LGNB = clog2(NB), and parameter-legality checks.
- One sub-module, wbsram_beat_timer: WAIT/GAP down-counter plus beat counter, outputting first_active, last_active, last_beat, and beat_idx.

Test Plan:
1. Default params; read wb addr 0x0123, model returns 0xBEEF at 0x0246 and 0xCAFE at 0x0247 -> ce_n/oe_n low in cycles 1-2 and 4-5; ack in cycle 6 with o_wb_data = 0xBEEFCAFE.
2. Write 0xDEADBEEF, sel 4'b1100, addr 5 -> RAM addr 0x0A, data 0xDEAD, sel 11 then 00. Next, RAM addr 0x0B, data 0xBEEF, sel 11 in both cycles; ack in cycle 6.
3. Second stb held through stall -> accepted in cycle 6 alongside ack 1; second ack in cycle 12; ce_n high in cycle 6.
4. i_wb_cyc dropped in cycle 3 of a read -> strobes finish in cycle 5, no ack, stall low in cycle 6.
5. i_reset_n low in cycle 3 -> cycle 4 has ce_n = 1, stall = 0, no ack; a later request completes normally.
6. DW=32, RAMDW=8, WAIT=3, GAP=1 read -> 4 beats with addr LSBs 0..3; ack in cycle 16. With WBSRAM_BYTESKIP_EN, a write with sel 4'b0001 strobes only beat 3.
